regfile_write_arbiter: RTL and testbench

- Owns the single register-file write port and shares it between the pipeline writeback stage and a long-latency execution unit (divider/multiplier) that returns results out of order.
- Long-latency results are buffered in a small FIFO and drained into idle writeback slots. A starvation counter forces a slot if the pipeline keeps the port busy.
- A 32-entry busy scoreboard tracks destinations of issued long-latency ops and produces the decode-stage hazard stall.

---
 rtl/regfile_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between pipeline writeback and
// buffered long-latency results, and tracks busy destinations for decode stalls.
module regfile_write_arbiter #(
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] w_result,
  input  logic [4:0]  w_rd,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_result,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic [4:0]  d_rd,
  output logic        hazard_stall,
  output logic        pipe_stall,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned STV_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned NREGS  = 32;

  logic [REG_W-1:0]  rd_mem_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic [NREGS-1:0]  busy_q, busy_d;

  logic              empty;
  logic              full;
  logic              push;
  logic              push_store;
  logic              force_grant;
  logic              fifo_grant;
  logic [REG_W-1:0]  head_rd;
  logic [DATA_W-1:0] head_data;

  assign empty       = (count_q == '0);
  assign full        = (count_q == CNT_W'(FIFO_DEPTH));
  assign push        = lu_valid && !full;
  // Results for x0 complete the handshake but never occupy a slot.
  assign push_store  = push && (lu_rd != '0);
  assign force_grant = (starve_q == STV_W'(STARVE_LIMIT)) && !empty;
  assign fifo_grant  = force_grant || ((w_rd == '0) && !empty);
  assign head_rd     = rd_mem_q[rd_ptr_q];
  assign head_data   = data_mem_q[rd_ptr_q];

  assign lu_ready     = reset && !full;
  assign hazard_stall = reset && (busy_q[d_rs1] || busy_q[d_rs2] || busy_q[d_rd]);

  // Write-port mux; everything is held low while reset is asserted.
  always_comb begin
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    pipe_stall = 1'b0;
    if (reset) begin
      if (fifo_grant) begin
        rf_we      = 1'b1;
        rf_waddr   = head_rd;
        rf_wdata   = head_data;
        pipe_stall = force_grant;
      end else if (w_rd != '0) begin
        rf_we    = 1'b1;
        rf_waddr = w_rd;
        rf_wdata = w_result;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    starve_d = starve_q;
    busy_d   = busy_q;

    if (push_store) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (fifo_grant) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_store) - CNT_W'(fifo_grant);

    if (empty || fifo_grant) begin
      starve_d = '0;
    end else if (starve_q != STV_W'(STARVE_LIMIT)) begin
      starve_d = starve_q + STV_W'(1);
    end

    // Clear before set so a same-cycle reissue keeps the register busy.
    if (fifo_grant) begin
      busy_d[head_rd] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        rd_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (push_store) begin
      rd_mem_q[wr_ptr_q]   <= lu_rd;
      data_mem_q[wr_ptr_q] <= lu_result;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scenario bench for regfile_write_arbiter; buffered writes are checked against
// a scoreboard queue filled as long-latency results are handed over.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        reset;
  logic [31:0] w_result;
  logic [4:0]  w_rd;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_rd;
  logic [31:0] lu_result;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  d_rs1;
  logic [4:0]  d_rs2;
  logic [4:0]  d_rd;
  logic        hazard_stall;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int   checks;
  int   errors;
  ent_t sb[$];
  ent_t e;

  regfile_write_arbiter #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .w_result(w_result), .w_rd(w_rd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_result(lu_result),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .hazard_stall(hazard_stall), .pipe_stall(pipe_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    w_result = '0; w_rd = '0; lu_valid = 1'b0; lu_rd = '0; lu_result = '0;
    issue_valid = 1'b0; issue_rd = '0; d_rs1 = '0; d_rs2 = '0; d_rd = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_inputs();
    w_rd = 5'd4; w_result = 32'h1;
    #3;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset_lu_ready got %b exp 0", lu_ready); end
    checks++; if (hazard_stall !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL reset_stalls got %b%b exp 00", hazard_stall, pipe_stall); end
    next(); next();
    reset = 1'b1;
    idle_inputs();
    settle();
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL post_reset_lu_ready got %b exp 1", lu_ready); end
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL post_reset_idle got we=%b a=%0d d=%h exp 0", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_pipeline_only();
    next();
    w_rd = 5'd5; w_result = 32'h1234;
    settle();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin errors++; $display("FAIL pipe_write got we=%b a=%0d d=%h exp 1/5/1234", rf_we, rf_waddr, rf_wdata); end
    checks++; if (pipe_stall !== 1'b0) begin errors++; $display("FAIL pipe_stall_idle got %b exp 0", pipe_stall); end
    next();
    w_rd = '0;
    settle();
    checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL pipe_idle got we=%b a=%0d d=%h exp 0", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_scoreboard();
    next();
    issue_valid = 1'b1; issue_rd = 5'd7; d_rs1 = 5'd7;
    settle();
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL sb_issue_cycle got %b exp 0", hazard_stall); end
    next();
    issue_valid = 1'b0;
    settle();
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL sb_rs1_busy got %b exp 1", hazard_stall); end
    d_rs1 = 5'd8; d_rd = 5'd7;
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL sb_rd_busy got %b exp 1", hazard_stall); end
    d_rd = 5'd9;
    #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL sb_other_reg got %b exp 0", hazard_stall); end
    d_rs2 = 5'd7; d_rs1 = 5'd7; d_rd = 5'd0;
    next();
    lu_valid = 1'b1; lu_rd = 5'd7; lu_result = 32'hDEAD; w_rd = '0;
    sb.push_back('{rd: 5'd7, data: 32'hDEAD});
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL sb_push_cycle_we got %b exp 0", rf_we); end
    next();
    lu_valid = 1'b0;
    settle();
    e = sb.pop_front();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== e.rd || rf_wdata !== e.data) begin errors++; $display("FAIL sb_lu_write got we=%b a=%0d d=%h exp 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e.rd, e.data); end
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL sb_busy_until_edge got %b exp 1", hazard_stall); end
    next();
    settle();
    checks++; if (hazard_stall !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL sb_cleared got hz=%b we=%b exp 0/0", hazard_stall, rf_we); end
    d_rs1 = '0; d_rs2 = '0;
  endtask

  task automatic test_fill_full();
    for (int i = 0; i < 4; i++) begin
      next();
      w_rd = 5'd9; w_result = 32'h55 + 32'(i);
      lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_result = 32'hA000 + 32'(i);
      settle();
      checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d got %b exp 1", i, lu_ready); end
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h55 + 32'(i)) begin errors++; $display("FAIL fill_pipe_%0d got a=%0d d=%h exp 9/%h", i, rf_waddr, rf_wdata, 32'h55 + 32'(i)); end
      sb.push_back('{rd: 5'(10 + i), data: 32'hA000 + 32'(i)});
    end
    next();
    lu_rd = 5'd20; lu_result = 32'hBAD;
    settle();
    checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", lu_ready); end
    next();
    lu_valid = 1'b0; w_rd = '0;
    for (int i = 0; i < 4; i++) begin
      settle();
      e = sb.pop_front();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== e.rd || rf_wdata !== e.data || pipe_stall !== 1'b0) begin errors++; $display("FAIL drain_%0d got we=%b a=%0d d=%h ps=%b exp 1/%0d/%h/0", i, rf_we, rf_waddr, rf_wdata, pipe_stall, e.rd, e.data); end
      next();
    end
    settle();
    checks++; if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin errors++; $display("FAIL drain_done got we=%b rdy=%b exp 0/1", rf_we, lu_ready); end
  endtask

  task automatic test_discard_rd0();
    next();
    lu_valid = 1'b1; lu_rd = 5'd0; lu_result = 32'hFFFF;
    settle();
    checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL rd0_ready got %b exp 1", lu_ready); end
    next();
    lu_valid = 1'b0;
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rd0_discard got we=%b a=%0d exp 0", rf_we, rf_waddr); end
  endtask

  task automatic test_starvation();
    next();
    w_rd = 5'd3; w_result = 32'h300;
    lu_valid = 1'b1; lu_rd = 5'd12; lu_result = 32'hC0DE;
    sb.push_back('{rd: 5'd12, data: 32'hC0DE});
    for (int i = 1; i <= 8; i++) begin
      next();
      lu_valid = 1'b0;
      w_rd = 5'(i); w_result = 32'h100 + 32'(i);
      settle();
      checks++; if (rf_waddr !== 5'(i) || pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_pipe_%0d got a=%0d ps=%b exp %0d/0", i, rf_waddr, pipe_stall, i); end
    end
    next();
    w_rd = 5'd9; w_result = 32'h909;
    settle();
    e = sb.pop_front();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== e.rd || rf_wdata !== e.data) begin errors++; $display("FAIL starve_force got we=%b a=%0d d=%h exp 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e.rd, e.data); end
    checks++; if (pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_pipe_stall got %b exp 1", pipe_stall); end
    next();
    settle();
    checks++; if (rf_waddr !== 5'd9 || rf_wdata !== 32'h909 || pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_held got a=%0d d=%h ps=%b exp 9/909/0", rf_waddr, rf_wdata, pipe_stall); end
    next();
    w_rd = 5'd1;
    lu_valid = 1'b1; lu_rd = 5'd13; lu_result = 32'hD00D;
    sb.push_back('{rd: 5'd13, data: 32'hD00D});
    for (int i = 0; i < 8; i++) begin
      next();
      lu_valid = 1'b0;
      settle();
      checks++; if (rf_waddr !== 5'd1 || pipe_stall !== 1'b0) begin errors++; $display("FAIL starve_restart_%0d got a=%0d ps=%b exp 1/0", i, rf_waddr, pipe_stall); end
    end
    next();
    settle();
    e = sb.pop_front();
    checks++; if (rf_waddr !== e.rd || rf_wdata !== e.data || pipe_stall !== 1'b1) begin errors++; $display("FAIL starve_force2 got a=%0d d=%h ps=%b exp %0d/%h/1", rf_waddr, rf_wdata, pipe_stall, e.rd, e.data); end
    next();
    w_rd = '0;
  endtask

  task automatic test_set_clear();
    next();
    issue_valid = 1'b1; issue_rd = 5'd3;
    next();
    issue_valid = 1'b0;
    w_rd = 5'd1; w_result = 32'h11;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_result = 32'h33;
    sb.push_back('{rd: 5'd3, data: 32'h33});
    next();
    lu_valid = 1'b0; w_rd = '0;
    issue_valid = 1'b1; issue_rd = 5'd3; d_rs1 = 5'd3;
    settle();
    e = sb.pop_front();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== e.rd || rf_wdata !== e.data) begin errors++; $display("FAIL setclr_write got we=%b a=%0d d=%h exp 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e.rd, e.data); end
    next();
    issue_valid = 1'b0;
    settle();
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL setclr_set_wins got %b exp 1", hazard_stall); end
    next();
    lu_valid = 1'b1; lu_rd = 5'd3; lu_result = 32'h34;
    next();
    lu_valid = 1'b0;
    next();
    settle();
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL setclr_final_clear got %b exp 0", hazard_stall); end
    next();
    issue_valid = 1'b1; issue_rd = 5'd0; d_rs1 = 5'd0;
    next();
    issue_valid = 1'b0;
    settle();
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL busy_x0 got %b exp 0", hazard_stall); end
  endtask

  task automatic test_async_reset();
    next();
    issue_valid = 1'b1; issue_rd = 5'd14;
    w_rd = 5'd2; w_result = 32'h22;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next();
      lu_valid = 1'b1; lu_rd = 5'(20 + i); lu_result = 32'hE000 + 32'(i);
      sb.push_back('{rd: 5'(20 + i), data: 32'hE000 + 32'(i)});
      if (i == 0) begin
        next();
        issue_valid = 1'b0;
        lu_rd = 5'(20 + i);
      end
    end
    next();
    lu_valid = 1'b0; w_rd = '0; d_rs1 = 5'd14;
    settle();
    e = sb.pop_front();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== e.rd || rf_wdata !== e.data) begin errors++; $display("FAIL ar_predrain got we=%b a=%0d d=%h exp 1/%0d/%h", rf_we, rf_waddr, rf_wdata, e.rd, e.data); end
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL ar_prehazard got %b exp 1", hazard_stall); end
    reset = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || lu_ready !== 1'b0 || hazard_stall !== 1'b0 || pipe_stall !== 1'b0) begin errors++; $display("FAIL ar_immediate got we=%b rdy=%b hz=%b ps=%b exp 0000", rf_we, lu_ready, hazard_stall, pipe_stall); end
    sb.delete();
    next(); next();
    reset = 1'b1;
    settle();
    checks++; if (rf_we !== 1'b0 || lu_ready !== 1'b1) begin errors++; $display("FAIL ar_empty got we=%b rdy=%b exp 0/1", rf_we, lu_ready); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL ar_busy_clear got %b exp 0", hazard_stall); end
    next();
    settle();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL ar_no_stale got we=%b a=%0d exp 0", rf_we, rf_waddr); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_pipeline_only();
    test_scoreboard();
    test_fill_full();
    test_discard_rd0();
    test_starvation();
    test_set_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
